// File: rtl/muldiv_iter.sv
// Iterative RV-M multiply/divide unit: shift-add multiply and restoring divide,
// one operand bit per cycle, with early resolution of divide-by-zero and signed overflow.
module muldiv_iter #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [TAGW-1:0] rd_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [TAGW-1:0] rd_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_n;

    logic [2:0]      op_q;
    logic [TAGW-1:0] rd_q;
    logic            neg_q;
    logic [XLEN:0]   hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] b_q;
    logic [CW-1:0]   cnt_q;

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_p(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    logic            accept;
    logic            a_neg, b_neg, div_zero, div_ovf, special;
    logic [XLEN-1:0] a_abs, b_abs, special_res;

    assign accept = (state == IDLE) && start_i && !kill_i;

    always_comb begin
        a_neg    = ((op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6))
                   && rs1_i[XLEN-1];
        b_neg    = ((op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6)) && rs2_i[XLEN-1];
        a_abs    = neg_x(rs1_i, a_neg);
        b_abs    = neg_x(rs2_i, b_neg);
        div_zero = op_i[2] && (rs2_i == '0);
        div_ovf  = op_i[2] && !op_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
        special  = div_zero || div_ovf;
        // REM-type ops return the dividend on zero divisor and zero on overflow
        if (div_zero) special_res = op_i[1] ? rs1_i : '1;
        else          special_res = op_i[1] ? '0 : rs1_i;
    end

    logic [XLEN:0]     mul_sum, div_shift, mul_hi_n, div_hi_n;
    logic [XLEN+1:0]   div_diff;
    logic [XLEN-1:0]   mul_lo_n, div_lo_n, fix_res;
    logic [2*XLEN-1:0] prod_s;

    always_comb begin
        mul_sum   = hi_q + {1'b0, (lo_q[0] ? b_q : {XLEN{1'b0}})};
        mul_hi_n  = {1'b0, mul_sum[XLEN:1]};
        mul_lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
        div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        div_hi_n  = div_diff[XLEN+1] ? div_shift : div_diff[XLEN:0];
        div_lo_n  = {lo_q[XLEN-2:0], !div_diff[XLEN+1]};
        prod_s    = neg_p({hi_q[XLEN-1:0], lo_q}, neg_q);
        case (op_q)
            3'd0:             fix_res = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fix_res = neg_x(lo_q, neg_q);
            default:          fix_res = neg_x(hi_q[XLEN-1:0], neg_q);
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = special ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_n = FIX;
            FIX:     state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill_i) state_n = IDLE;
    end

    // Iteration registers: lo_q holds the multiplier (LSB out) or dividend/quotient (MSB out)
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op_i;
            rd_q  <= rd_i;
            neg_q <= (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);
            hi_q  <= '0;
            lo_q  <= op_i[2] ? a_abs : b_abs;
            b_q   <= op_i[2] ? b_abs : a_abs;
            cnt_q <= CW'(XLEN-1);
        end else if (state == CALC) begin
            hi_q  <= op_q[2] ? div_hi_n : mul_hi_n;
            lo_q  <= op_q[2] ? div_lo_n : mul_lo_n;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            state   <= state_n;
            busy_o  <= (state_n != IDLE);
            valid_o <= (state_n == DONE);
            if (accept && special) begin
                result_o <= special_res;
                rd_o     <= rd_i;
            end else if ((state == FIX) && !kill_i) begin
                result_o <= fix_res;
                rd_o     <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at XLEN=32 and XLEN=16 with a scoreboard of
// expected results produced by an integer reference model.
module tb_muldiv_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s32, k32, busy32, valid32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, res32;
    logic [4:0]  rdi32, rdo32;
    logic        s16, k16, busy16, valid16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, res16;
    logic [4:0]  rdi16, rdo16;

    muldiv_iter #(.XLEN(32), .TAGW(5)) dut32 (
        .clk(clk), .rst(rst), .start_i(s32), .kill_i(k32), .op_i(op32),
        .rs1_i(a32), .rs2_i(b32), .rd_i(rdi32), .busy_o(busy32),
        .valid_o(valid32), .result_o(res32), .rd_o(rdo32)
    );

    muldiv_iter #(.XLEN(16), .TAGW(5)) dut16 (
        .clk(clk), .rst(rst), .start_i(s16), .kill_i(k16), .op_i(op16),
        .rs1_i(a16), .rs2_i(b16), .rd_i(rdi16), .busy_o(busy16),
        .valid_o(valid16), .result_o(res16), .rd_o(rdo16)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] last_res;
    logic [4:0]  last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int xl);
        longint m, ua, ub, sa, sbv, r;
        logic [63:0] p;
        bit ovf;
        m   = (longint'(1) << xl) - 1;
        ua  = {32'b0, a} & m;
        ub  = {32'b0, b} & m;
        sa  = (ua >= (longint'(1) << (xl-1))) ? ua - (longint'(1) << xl) : ua;
        sbv = (ub >= (longint'(1) << (xl-1))) ? ub - (longint'(1) << xl) : ub;
        ovf = (sa == -(longint'(1) << (xl-1))) && (sbv == -1);
        p   = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p; end
            3'd1: begin p = sa * sbv; r = p >> xl; end
            3'd2: begin p = sa * ub; r = p >> xl; end
            3'd3: begin p = ua * ub; r = p >> xl; end
            3'd4: r = (ub == 0) ? m : (ovf ? ua : sa / sbv);
            3'd5: r = (ub == 0) ? m : ua / ub;
            3'd6: r = (ub == 0) ? ua : (ovf ? 0 : sa % sbv);
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & m);
    endfunction

    task automatic drive(input bit w16, input bit s, input bit k, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        if (w16) begin
            s16 = s; k16 = k; op16 = op; a16 = a[15:0]; b16 = b[15:0]; rdi16 = rd;
        end else begin
            s32 = s; k32 = k; op32 = op; a32 = a; b32 = b; rdi32 = rd;
        end
    endtask

    task automatic run_op(input bit w16, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input bit pulse,
                          input string tag);
        int          xl, k, busy_n;
        bit          got, spec;
        logic [31:0] m, mn;
        exp_t        e, ne;
        xl   = w16 ? 16 : 32;
        m    = (xl == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        mn   = 32'h1 << (xl - 1);
        spec = op[2] && (((b & m) == 0) || (!op[0] && ((a & m) == mn) && ((b & m) == m)));
        e.res = ref_op(op, a, b, xl);
        e.rd  = rd;
        e.lat = spec ? 0 : xl + 1;
        sb.push_back(e);
        drive(w16, 1'b1, 1'b0, op, a, b, rd);
        @(negedge clk);
        drive(w16, 1'b0, 1'b0, op, a, b, rd);
        k = 0; busy_n = 0; got = 0;
        while (k < 200) begin
            if (w16 ? busy16 : busy32) busy_n++;
            if (w16 ? valid16 : valid32) begin got = 1; break; end
            if (pulse && k >= 2 && k < 6) drive(w16, 1'b1, 1'b0, ~op, ~a, a ^ b, ~rd);
            else if (pulse) drive(w16, 1'b0, 1'b0, op, a, b, rd);
            @(negedge clk);
            k++;
        end
        ne = sb.pop_front();
        check({tag, "/valid_seen"}, 32'(got), 32'd1);
        check({tag, "/latency"}, k, ne.lat);
        check({tag, "/result"}, w16 ? {16'b0, res16} : res32, ne.res);
        check({tag, "/rd"}, w16 ? rdo16 : rdo32, ne.rd);
        check({tag, "/busy_cycles"}, busy_n, ne.lat + 1);
        if (!w16) begin last_res = ne.res; last_rd = ne.rd; end
        @(negedge clk);
        check({tag, "/busy_after"}, 32'(w16 ? busy16 : busy32), 32'd0);
        check({tag, "/valid_after"}, 32'(w16 ? valid16 : valid32), 32'd0);
    endtask

    task automatic expect_quiet32(input string tag, input int cycles);
        int nv;
        nv = 0;
        for (int i = 0; i < cycles; i++) begin
            if (valid32) nv++;
            @(negedge clk);
        end
        check({tag, "/no_valid"}, nv, 0);
        check({tag, "/result_kept"}, res32, last_res);
        check({tag, "/rd_kept"}, rdo32, last_rd);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        repeat (3) @(negedge clk);
        check("reset/busy32", 32'(busy32), 32'd0);
        check("reset/valid32", 32'(valid32), 32'd0);
        check("reset/result32", res32, 32'd0);
        check("reset/rd32", rdo32, 5'd0);
        check("reset/busy16", 32'(busy16), 32'd0);
        check("reset/result16", {16'b0, res16}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, "mul");
        run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0, "mulh");
        run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, "mulhu");
        run_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, "mulhsu");
        run_op(0, 3'd0, 32'h8000_0000, 32'h8000_0000, 5'd4, 0, "mul_min");
        run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, "div");
        run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, "rem");
        run_op(0, 3'd5, 32'd100, 32'd7, 5'd8, 0, "divu");
        run_op(0, 3'd7, 32'd100, 32'd7, 5'd9, 0, "remu");
        run_op(0, 3'd5, 32'd5, 32'd0, 5'd10, 0, "divu_zero");
        run_op(0, 3'd6, 32'd5, 32'd0, 5'd11, 0, "rem_zero");
        run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, "div_ovf");
        run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, "rem_ovf");
        run_op(0, 3'd6, 32'h0000_0013, 32'hFFFF_FFFB, 5'd14, 0, "rem_negdiv");
        for (int i = 0; i < 6; i++)
            run_op(0, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'(16 + i), 0, "random");

        // Kill in the middle of CALC
        drive(0, 1'b1, 1'b0, 3'd4, 32'd1000, 32'd3, 5'd20);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 3'd4, 32'd1000, 32'd3, 5'd20);
        repeat (10) @(negedge clk);
        k32 = 1'b1;
        @(negedge clk);
        k32 = 1'b0;
        check("kill/busy_low", 32'(busy32), 32'd0);
        expect_quiet32("kill", 40);
        run_op(0, 3'd5, 32'd1000, 32'd3, 5'd21, 0, "after_kill");

        // Kill together with start in IDLE
        drive(0, 1'b1, 1'b1, 3'd0, 32'd3, 32'd3, 5'd22);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 3'd0, 32'd3, 32'd3, 5'd22);
        check("kill_start/busy", 32'(busy32), 32'd0);
        expect_quiet32("kill_start", 40);

        // Reset mid-divide
        drive(0, 1'b1, 1'b0, 3'd7, 32'd12345, 32'd17, 5'd23);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 3'd7, 32'd12345, 32'd17, 5'd23);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid/busy", 32'(busy32), 32'd0);
        check("rst_mid/valid", 32'(valid32), 32'd0);
        check("rst_mid/result", res32, 32'd0);
        check("rst_mid/rd", rdo32, 5'd0);
        last_res = '0; last_rd = '0;
        expect_quiet32("rst_mid", 40);

        run_op(0, 3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5'd24, 1, "ignored_starts");

        run_op(1, 3'd0, 32'd7, 32'h0000_FFFD, 5'd5, 0, "mul16");
        run_op(1, 3'd1, 32'h0000_8000, 32'h0000_8000, 5'd1, 0, "mulh16");
        run_op(1, 3'd4, 32'h0000_FFF9, 32'd2, 5'd6, 0, "div16");
        run_op(1, 3'd6, 32'h0000_FFF9, 32'd2, 5'd7, 0, "rem16");
        run_op(1, 3'd5, 32'd5, 32'd0, 5'd10, 0, "divu_zero16");
        run_op(1, 3'd4, 32'h0000_8000, 32'h0000_FFFF, 5'd12, 0, "div_ovf16");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
